// File: rtl/ganzzahl_divwurzel.sv
// ganzzahl_divwurzel -- iterative integer divide / modulo / square-root unit.
//
// Operands are captured on a start handshake. The unit then prepares the
// operands, iterates BITS_PRO_TAKT quotient/root bits per clock, applies the
// sign fix and returns one result together with a single-cycle done pulse.
//
// Parameters
//   BREITE         operand/result width. Must be even and a multiple of
//                  2*BITS_PRO_TAKT.
//   BITS_PRO_TAKT  quotient/root bits resolved per clock (1 or 2).
//
// Ports
//   Clock               rising-edge clock
//   Reset               synchronous, active-high reset
//   Daten1              dividend / radicand
//   Daten2              divisor (ignored for sqrt)
//   FunktionsCode       000 sdiv, 001 smod, 010 udiv, 011 umod, 100 usqrt,
//                       101..111 illegal
//   StartSignal         request, sampled only while Bereit=1
//   Bereit              idle, able to accept a start
//   HatFertigGerechnet  one-cycle pulse when Ergebnis/flags update
//   Ergebnis            result, held until next completion or reset
//   DurchNull           last completed div/mod had a zero divisor
//   Fehler              last completed request had an illegal code
module ganzzahl_divwurzel #(
  parameter int BREITE        = 32,
  parameter int BITS_PRO_TAKT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [BREITE-1:0] Daten1,
  input  logic [BREITE-1:0] Daten2,
  input  logic [2:0]        FunktionsCode,
  input  logic              StartSignal,
  output logic              Bereit,
  output logic              HatFertigGerechnet,
  output logic [BREITE-1:0] Ergebnis,
  output logic              DurchNull,
  output logic              Fehler
);

  localparam int HALB    = BREITE / 2;
  localparam int N_DIV   = BREITE / BITS_PRO_TAKT;
  localparam int N_WURZ  = BREITE / (2 * BITS_PRO_TAKT);
  localparam int CW      = $clog2(N_DIV + 1);
  localparam logic [CW-1:0] N_DIV_C  = CW'(N_DIV);
  localparam logic [CW-1:0] N_WURZ_C = CW'(N_WURZ);

  typedef enum logic [1:0] {IDLE, VORB, RECHNEN, KORR} zustandT;
  zustandT zustand;

  // Latched request
  logic [BREITE-1:0] d1, d2;   // d2 holds |divisor| after VORB
  logic [2:0]        code;

  // Iteration state. quot doubles as the radicand shift register for sqrt.
  logic [BREITE:0]   rest;
  logic [BREITE-1:0] quot;
  logic [HALB+1:0]   srem;
  logic [HALB-1:0]   root;
  logic [CW-1:0]     zaehler;
  logic              qNeg, rNeg;

  logic istWurzel, istIllegal, istSigned;
  assign istWurzel  = (code == 3'b100);
  assign istIllegal = code[2] && (code != 3'b100);
  assign istSigned  = (code[2:1] == 2'b00);

  // Operand preparation: magnitudes and result signs for the signed codes.
  // -MIN wraps to MIN, which read as unsigned is the correct magnitude.
  logic              neg1, neg2;
  logic [BREITE-1:0] absA, absB;
  assign neg1 = istSigned && d1[BREITE-1];
  assign neg2 = istSigned && d2[BREITE-1];
  assign absA = neg1 ? -d1 : d1;
  assign absB = neg2 ? -d2 : d2;

  // One clock worth of shift-subtract (div) or digit-by-digit root steps.
  logic [BREITE:0]   restN;
  logic [BREITE-1:0] quotN;
  logic [HALB+1:0]   sremN, versuch;
  logic [HALB-1:0]   rootN;

  always_comb begin
    restN   = rest;
    quotN   = quot;
    sremN   = srem;
    rootN   = root;
    versuch = '0;
    for (int i = 0; i < BITS_PRO_TAKT; i++) begin
      if (istWurzel) begin
        // Bring down the next two radicand bits, try root*4+1.
        sremN   = {sremN[HALB-1:0], quotN[BREITE-1 -: 2]};
        quotN   = quotN << 2;
        versuch = {rootN, 2'b01};
        if (sremN >= versuch) begin
          sremN = sremN - versuch;
          rootN = {rootN[HALB-2:0], 1'b1};
        end else begin
          rootN = {rootN[HALB-2:0], 1'b0};
        end
      end else begin
        // Dividend bits shift out of quot into rest; quotient bits shift in.
        restN = {restN[BREITE-1:0], quotN[BREITE-1]};
        quotN = quotN << 1;
        if (restN >= {1'b0, d2}) begin
          restN    = restN - {1'b0, d2};
          quotN[0] = 1'b1;
        end
      end
    end
  end

  logic [BREITE-1:0] qErg, rErg;
  assign qErg = qNeg ? -quot : quot;
  assign rErg = rNeg ? -rest[BREITE-1:0] : rest[BREITE-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand            <= IDLE;
      Bereit             <= 1'b1;
      HatFertigGerechnet <= 1'b0;
      Ergebnis           <= '0;
      DurchNull          <= 1'b0;
      Fehler             <= 1'b0;
    end else begin
      HatFertigGerechnet <= 1'b0;
      case (zustand)
        IDLE: begin
          if (StartSignal) begin
            d1      <= Daten1;
            d2      <= Daten2;
            code    <= FunktionsCode;
            Bereit  <= 1'b0;
            zustand <= VORB;
          end
        end
        VORB: begin
          quot <= absA;
          d2   <= absB;
          rest <= '0;
          srem <= '0;
          root <= '0;
          qNeg <= neg1 ^ neg2;
          rNeg <= neg1;
          if (istIllegal) begin
            Ergebnis           <= '0;
            Fehler             <= 1'b1;
            DurchNull          <= 1'b0;
            HatFertigGerechnet <= 1'b1;
            Bereit             <= 1'b1;
            zustand            <= IDLE;
          end else if (!istWurzel && d2 == '0) begin
            // Remainder on zero divisor is the raw latched dividend.
            Ergebnis           <= code[0] ? d1 : '1;
            Fehler             <= 1'b0;
            DurchNull          <= 1'b1;
            HatFertigGerechnet <= 1'b1;
            Bereit             <= 1'b1;
            zustand            <= IDLE;
          end else begin
            zaehler <= istWurzel ? N_WURZ_C : N_DIV_C;
            zustand <= RECHNEN;
          end
        end
        RECHNEN: begin
          rest    <= restN;
          quot    <= quotN;
          srem    <= sremN;
          root    <= rootN;
          zaehler <= zaehler - 1'b1;
          if (zaehler == CW'(1)) zustand <= KORR;
        end
        KORR: begin
          if (istWurzel)    Ergebnis <= {{(BREITE-HALB){1'b0}}, root};
          else if (code[0]) Ergebnis <= rErg;
          else              Ergebnis <= qErg;
          DurchNull          <= 1'b0;
          Fehler             <= 1'b0;
          HatFertigGerechnet <= 1'b1;
          Bereit             <= 1'b1;
          zustand            <= IDLE;
        end
        default: zustand <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ganzzahl_divwurzel.sv
// Bench for ganzzahl_divwurzel: a 32/1 instance (A) and a 16/2 instance (B)
// driven by directed and random requests, checked against an arithmetic
// reference model.
module tb_ganzzahl_divwurzel;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  // Instance A: 32 bits, 1 bit per clock
  logic [31:0] d1A = '0, d2A = '0, ergA;
  logic [2:0]  fcA = '0;
  logic        stA = 1'b0, rdyA, doneA, dzA, flA;

  // Instance B: 16 bits, 2 bits per clock
  logic [15:0] d1B = '0, d2B = '0, ergB;
  logic [2:0]  fcB = '0;
  logic        stB = 1'b0, rdyB, doneB, dzB, flB;

  ganzzahl_divwurzel #(.BREITE(32), .BITS_PRO_TAKT(1)) dutA (
    .Clock(Clock), .Reset(Reset), .Daten1(d1A), .Daten2(d2A),
    .FunktionsCode(fcA), .StartSignal(stA), .Bereit(rdyA),
    .HatFertigGerechnet(doneA), .Ergebnis(ergA), .DurchNull(dzA), .Fehler(flA));

  ganzzahl_divwurzel #(.BREITE(16), .BITS_PRO_TAKT(2)) dutB (
    .Clock(Clock), .Reset(Reset), .Daten1(d1B), .Daten2(d2B),
    .FunktionsCode(fcB), .StartSignal(stB), .Bereit(rdyB),
    .HatFertigGerechnet(doneB), .Ergebnis(ergB), .DurchNull(dzB), .Fehler(flB));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic logic [63:0] refModel(input int w, input int bpt, input logic [2:0] c,
                                           input logic [63:0] a, input logic [63:0] b,
                                           output bit dz, output bit il, output int lat);
    logic [63:0] mask, r, t;
    longint sa, sb;
    mask = (64'd1 << w) - 1;
    a &= mask;
    b &= mask;
    dz = 0; il = 0;
    lat = w / bpt + 2;
    if (c > 3'd4) begin
      il = 1; lat = 1;
      return 64'd0;
    end
    if (c == 3'd4) begin
      lat = w / (2 * bpt) + 2;
      r = 0;
      for (int i = w / 2 - 1; i >= 0; i--) begin
        t = r | (64'd1 << i);
        if (t * t <= a) r = t;
      end
      return r;
    end
    if (b == 0) begin
      dz = 1; lat = 1;
      return c[0] ? a : mask;
    end
    if (c[1]) return (c[0] ? a % b : a / b);
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    return (c[0] ? 64'(sa % sb) : 64'(sa / sb)) & mask;
  endfunction

  // Issue one request. When chained, the caller is in a completion cycle
  // (just after the edge) and the start is sampled at the very next edge.
  task automatic doOp(input string tag, input bit sel, input logic [2:0] c,
                      input logic [31:0] a, input logic [31:0] b, input bit chained);
    bit dz, il;
    int lat, n;
    logic [63:0] exp;
    exp = refModel(sel ? 16 : 32, sel ? 2 : 1, c, 64'(a), 64'(b), dz, il, lat);
    if (!chained) @(negedge Clock);
    if (sel) begin d1B = a[15:0]; d2B = b[15:0]; fcB = c; stB = 1'b1; end
    else     begin d1A = a;       d2A = b;       fcA = c; stA = 1'b1; end
    @(posedge Clock);  // edge k
    #1;
    stA = 1'b0; stB = 1'b0;
    // Later input changes must not matter.
    d1A = $urandom; d2A = $urandom; fcA = 3'($urandom);
    d1B = 16'($urandom); d2B = 16'($urandom); fcB = 3'($urandom);
    n = 0;
    while (n < 200) begin
      @(posedge Clock);
      n++;
      #1;
      if (sel ? doneB : doneA) break;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_erg"}, sel ? 64'(ergB) : 64'(ergA), exp);
    chk({tag, "_dz"},  64'(sel ? dzB : dzA), 64'(dz));
    chk({tag, "_fl"},  64'(sel ? flB : flA), 64'(il));
    chk({tag, "_rdy"}, 64'(sel ? rdyB : rdyA), 64'd1);
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;
    logic [2:0]  rc;
    logic [31:0] ra, rb;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_rdy",  64'(rdyA), 64'd1);
    chk("rst_done", 64'(doneA), 64'd0);
    chk("rst_erg",  64'(ergA), 64'd0);
    chk("rst_dz",   64'(dzA), 64'd0);
    chk("rst_fl",   64'(flA), 64'd0);
    chk("rst_ergB", 64'(ergB), 64'd0);
    Reset = 1'b0;

    // Directed, 32/1
    doOp("sdiv_m7_2", 0, 3'b000, 32'hFFFF_FFF9, 32'd2, 0);
    chk("sdiv_m7_2_const", 64'(ergA), 64'h0000_0000_FFFF_FFFD);
    doOp("smod_m7_2", 0, 3'b001, 32'hFFFF_FFF9, 32'd2, 0);
    chk("smod_m7_2_const", 64'(ergA), 64'h0000_0000_FFFF_FFFF);
    doOp("sdiv_ovf", 0, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("sdiv_ovf_const", 64'(ergA), 64'h0000_0000_8000_0000);
    doOp("smod_ovf", 0, 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    doOp("udiv_z",   0, 3'b010, 32'd100, 32'd0, 0);
    chk("udiv_z_const", 64'(ergA), 64'h0000_0000_FFFF_FFFF);
    doOp("umod_z",   0, 3'b011, 32'd100, 32'd0, 0);
    chk("umod_z_const", 64'(ergA), 64'd100);
    doOp("illegal",  0, 3'b110, 32'd5, 32'd3, 0);
    doOp("sqrt_max", 0, 3'b100, 32'hFFFF_FFFF, 32'd0, 0);
    chk("sqrt_max_const", 64'(ergA), 64'h0000_FFFF);
    doOp("sqrt_15",  0, 3'b100, 32'd15, 32'd7, 0);
    chk("sqrt_15_const", 64'(ergA), 64'd3);
    doOp("sqrt_16",  0, 3'b100, 32'd16, 32'd0, 0);
    chk("sqrt_16_const", 64'(ergA), 64'd4);
    doOp("smod_neg_z", 0, 3'b001, 32'hFFFF_FF00, 32'd0, 0);

    // Reset mid-operation: asserted so that it is sampled at edge k+10
    @(negedge Clock);
    d1A = 32'd1000; d2A = 32'd3; fcA = 3'b010; stA = 1'b1;
    @(posedge Clock);
    #1 stA = 1'b0;
    pulses = 0;
    repeat (9) begin @(posedge Clock); #1 if (doneA) pulses++; end
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    chk("rstmid_rdy",  64'(rdyA), 64'd1);
    chk("rstmid_erg",  64'(ergA), 64'd0);
    chk("rstmid_dz",   64'(dzA), 64'd0);
    // Reset has priority over a simultaneous start
    stA = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0; stA = 1'b0;
    chk("rstprio_rdy", 64'(rdyA), 64'd1);
    repeat (45) begin @(posedge Clock); #1 if (doneA) pulses++; end
    chk("rstmid_nodone", 64'(pulses), 64'd0);

    // Start toggled while busy: one pulse, first operation's result
    @(negedge Clock);
    d1A = 32'd1000; d2A = 32'd7; fcA = 3'b010; stA = 1'b1;
    @(posedge Clock);
    pulses = 0; seen = '0;
    #1 stA = 1'b0;
    @(posedge Clock);
    #1 chk("busy_rdy0", 64'(rdyA), 64'd0);
    for (int i = 0; i < 50; i++) begin
      if (i < 28) begin
        stA = ~stA; d1A = $urandom; d2A = $urandom; fcA = 3'($urandom);
      end else begin
        stA = 1'b0;
      end
      @(posedge Clock);
      #1 if (doneA) begin pulses++; seen = ergA; end
    end
    chk("busy_pulses", 64'(pulses), 64'd1);
    chk("busy_erg",    64'(seen), 64'd142);

    // Parametrised 16/2 and back-to-back start in the completion cycle
    doOp("b_udiv", 1, 3'b010, 32'h0000_FFFF, 32'd3, 0);
    chk("b_udiv_const", 64'(ergB), 64'h5555);
    doOp("b_chain", 1, 3'b000, 32'h0000_8001, 32'h0000_0007, 1);
    @(posedge Clock);
    #1 chk("b_pulse1", 64'(doneB), 64'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      if (rc > 3'd5) rc = 3'($urandom_range(0, 4));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      doOp($sformatf("rndA%0d", i), 0, rc, ra, rb, 0);
    end
    for (int i = 0; i < 30; i++) begin
      rc = 3'($urandom_range(0, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
      doOp($sformatf("rndB%0d", i), 1, rc, ra, rb, i[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ganzzahl_divwurzel.md
# ganzzahl_divwurzel

Parametrised sequential integer divide/modulo/square-root unit for the processor's ALU path, replacing fixed-width, fixed-latency long operations with a width-generic iterative datapath. It captures operands on a start handshake, iterates a configurable number of quotient/root bits per clock, and returns one result with a single-cycle completion pulse. It also flags divide-by-zero and illegal codes. The instantiating ALU stalls on `Bereit` and `HatFertigGerechnet`.

## Interface
- `BREITE`, default 32: operand and result width. Must be even and a multiple of 2·`BITS_PRO_TAKT`.
- `BITS_PRO_TAKT`, default 1: quotient/root bits resolved per clock. Legal values are 1 and 2.
- `Clock`, input, 1: the single clock. All state changes on its rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Daten1`, input, `BREITE`: dividend or radicand.
- `Daten2`, input, `BREITE`: divisor. Ignored for square root.
- `FunktionsCode`, input, 3: operation select.
  - 000: signed div
  - 001: signed mod
  - 010: unsigned div
  - 011: unsigned mod
  - 100: unsigned integer sqrt
  - 101–111: illegal
- `StartSignal`, input, 1: request. Sampled only when `Bereit`=1.
- `Bereit`, output, 1: unit idle and able to accept a start.
- `HatFertigGerechnet`, output, 1: one-cycle pulse when `Ergebnis`/flags are updated.
- `Ergebnis`, output, `BREITE`: result. Held until the next completion or reset.
- `DurchNull`, output, 1: last completed div/mod had a zero divisor. Held with `Ergebnis`.
- `Fehler`, output, 1: last completed request had an illegal code. Held with `Ergebnis`.

## Operation
- **States:**
  - IDLE
  - VORB (operand preparation)
  - RECHNEN (iteration)
  - KORR (sign fix and result register)
- **IDLE:**
  - `Bereit`=1.
  - On `StartSignal`=1, latch `Daten1`, `Daten2` and `FunktionsCode`, then go to VORB.
  - Inputs changing after the start edge have no effect.
- **VORB:**
  - Signed codes: take absolute values and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - Divisor zero (codes 000–011): go to IDLE and complete with quotient = all ones, remainder = dividend as latched (unsigned/raw bits), `DurchNull`=1.
  - Illegal code: go to IDLE and complete with `Ergebnis`=0, `Fehler`=1.
  - Otherwise: load the iteration counter with N and go to RECHNEN.
    - Div/mod: N = `BREITE`/`BITS_PRO_TAKT`.
    - Sqrt: N = `BREITE`/(2·`BITS_PRO_TAKT`).
- **RECHNEN:**
  - Div/mod: restoring division, `BITS_PRO_TAKT` shift-subtract steps per clock. Partial remainder is `BREITE`+1 bits wide.
  - Sqrt: digit-by-digit root, two radicand bits consumed per root bit. Partial remainder is `BREITE`/2+2 bits wide.
  - Counter decrements each clock; at 1 go to KORR.
- **KORR:**
  - Negate the quotient if its sign is negative; negate the remainder if the dividend was negative. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - Overflow case most-negative / −1 yields quotient = most-negative and remainder = 0, with no flag.
  - Sqrt result is floor(√`Daten1`) in the low `BREITE`/2 bits, upper bits zero.
  - Register `Ergebnis` (quotient or remainder per code), clear `DurchNull`/`Fehler`, pulse `HatFertigGerechnet`, go to IDLE.
- **Start while busy:** `StartSignal` when `Bereit`=0 is ignored and not queued.
- **Reset (any state, including mid-operation):**
  - Next state IDLE, `Bereit`=1, `HatFertigGerechnet`=0.
  - `Ergebnis`=0, `DurchNull`=0, `Fehler`=0.
  - The aborted operation never signals completion.
  - `Reset` has priority over a simultaneous `StartSignal`.

## Timing
- Start accepted at edge k.
- **Regular div/mod/sqrt:**
  - `Ergebnis`, flags and `HatFertigGerechnet`=1 are valid in the cycle after edge k+N+2.
  - `Bereit`=1 in that same cycle, so the next start can be sampled at edge k+N+3. Throughput is one operation per N+3 cycles.
- **Divide-by-zero and illegal code:** completion is visible in the cycle after edge k+1, and `Bereit`=1 in that cycle.
- `Bereit`=0 from the cycle after edge k until the completion cycle.
- `HatFertigGerechnet` is high for exactly one cycle per accepted start.
- Default configuration: div/mod latency 34 edges, sqrt 18 edges.

## Test plan
- **Signed div/mod (32/1):** `Daten1`=0xFFFFFFF9 (−7), `Daten2`=2.
  - Code 000 → `Ergebnis`=0xFFFFFFFD, done exactly after edge k+34.
  - Code 001 → 0xFFFFFFFF.
  - `DurchNull`=0.
- **Signed overflow (32/1):** 0x80000000 / 0xFFFFFFFF.
  - Code 000 → 0x80000000.
  - Code 001 → 0x00000000.
  - No flags set.
- **Divide by zero (32/1):** 100 / 0.
  - Code 010 → 0xFFFFFFFF.
  - Code 011 → 100.
  - `DurchNull`=1 and done after edge k+1.
  - Illegal code 110 → `Ergebnis`=0, `Fehler`=1, done after edge k+1.
- **Square root (32/1):**
  - √0xFFFFFFFF → 0x0000FFFF.
  - √15 → 3.
  - √16 → 4.
  - Done after edge k+18.
- **Reset and busy start (32/1):**
  - Start a div, then assert `Reset` at edge k+10 → no done pulse, `Bereit`=1 and `Ergebnis`=0 from the next cycle.
  - A separate run with `StartSignal` toggled while busy → exactly one done pulse, with the first operation's result.
- **Parametrised (16/2):** 0xFFFF / 3, code 010 → 0x5555, done after edge k+10.
  - A back-to-back start in the completion cycle is accepted and completes after a further 10 edges.
